booth_controller: RTL and testbench

- Control FSM for the 16-bit Booth radix-2 multiplier datapath; sits directly upstream of that datapath.
- Accepts a start request and sequences operand loading over the shared `data_in` bus.
- Runs N add/sub-and-shift iterations, driving the datapath load, clear, shift and add/sub strobes from the datapath's `q0` and `qm1` status bits.
- Signals completion with a one-cycle `done` pulse; the product is then valid in {A,Q}.

---
 rtl/booth_controller.sv | 113 +++++++++++
 tb/tb_booth_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/booth_controller.sv
// rtl/booth_controller.sv - sequencing FSM for a radix-2 Booth multiplier datapath
// Decodes load/clear/shift/add-sub strobes from state and the datapath's q0/qm1 bits.
module booth_controller #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic q0,
  input  logic qm1,
  output logic opnd_sel,
  output logic ldM,
  output logic ldQ,
  output logic ldA,
  output logic clrA,
  output logic clrff,
  output logic sftA,
  output logic sftQ,
  output logic addsub,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDM,
    S_LDQ,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (abort && state != S_IDLE) begin
        cnt <= '0;
      end else if (state == S_LDQ) begin
        cnt <= CNT_INIT;
      end else if (state == S_SHIFT) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    opnd_sel  = 1'b0;
    ldM       = 1'b0;
    ldQ       = 1'b0;
    ldA       = 1'b0;
    clrA      = 1'b0;
    clrff     = 1'b0;
    sftA      = 1'b0;
    sftQ      = 1'b0;
    addsub    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LDM;
      end
      S_LDM: begin
        ldM       = 1'b1;
        clrA      = 1'b1;
        clrff     = 1'b1;
        busy      = 1'b1;
        state_nxt = S_LDQ;
      end
      S_LDQ: begin
        ldQ       = 1'b1;
        opnd_sel  = 1'b1;
        busy      = 1'b1;
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        busy      = 1'b1;
        // 01 adds M, 10 subtracts M; equal bits leave A untouched
        ldA       = q0 ^ qm1;
        addsub    = ~q0 & qm1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        sftA      = 1'b1;
        sftQ      = 1'b1;
        busy      = 1'b1;
        state_nxt = (cnt == CNT_ONE) ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

endmodule

// File: tb/tb_booth_controller.sv
// tb/tb_booth_controller.sv - directed self-checking bench for booth_controller
// Forced q0/qm1 patterns plus a closed loop through a behavioural Booth datapath.
module tb_booth_controller;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic start1 = 1'b0;
  logic abort  = 1'b0;
  logic fq0    = 1'b0;
  logic fqm1   = 1'b0;
  logic closed = 1'b0;
  logic q0, qm1;

  logic opnd_sel, ldM, ldQ, ldA, clrA, clrff, sftA, sftQ, addsub, busy, done;
  logic opnd_sel_1, ldM_1, ldQ_1, ldA_1, clrA_1, clrff_1, sftA_1, sftQ_1, addsub_1, busy_1, done_1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_controller #(.N(16), .CW(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .q0(q0), .qm1(qm1),
    .opnd_sel(opnd_sel), .ldM(ldM), .ldQ(ldQ), .ldA(ldA), .clrA(clrA), .clrff(clrff),
    .sftA(sftA), .sftQ(sftQ), .addsub(addsub), .busy(busy), .done(done)
  );

  booth_controller #(.N(1), .CW(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .q0(fq0), .qm1(fqm1),
    .opnd_sel(opnd_sel_1), .ldM(ldM_1), .ldQ(ldQ_1), .ldA(ldA_1), .clrA(clrA_1), .clrff(clrff_1),
    .sftA(sftA_1), .sftQ(sftQ_1), .addsub(addsub_1), .busy(busy_1), .done(done_1)
  );

  // Behavioural datapath; A carries a guard bit so M = -2^15 multiplies correctly
  logic [16:0] dp_a;
  logic [15:0] dp_q, dp_m, mcand, mplier, data_in;
  logic        dp_qm1;

  assign data_in = opnd_sel ? mplier : mcand;
  assign q0      = closed ? dp_q[0] : fq0;
  assign qm1     = closed ? dp_qm1  : fqm1;

  always @(posedge clk) begin
    if (ldM)   dp_m   <= data_in;
    if (ldQ)   dp_q   <= data_in;
    if (clrA)  dp_a   <= '0;
    if (clrff) dp_qm1 <= 1'b0;
    if (ldA)   dp_a   <= addsub ? dp_a + {dp_m[15], dp_m} : dp_a - {dp_m[15], dp_m};
    if (sftA) begin
      dp_a   <= {dp_a[16], dp_a[16:1]};
      dp_q   <= {dp_a[0], dp_q[15:1]};
      dp_qm1 <= dp_q[0];
    end
  end

  logic [127:0] busy_v, done_v, ldm_v, ldq_v, sft_v;
  int           n_lda, n_add, n_sft;
  logic [31:0]  prod;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] evens(input int lo, input int hi);
    logic [127:0] m = '0;
    for (int i = lo; i <= hi; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  task automatic run_op(input int ncyc, input int abort_at, input bit hold, input bit abort_on_start);
    busy_v = '0; done_v = '0; ldm_v = '0; ldq_v = '0; sft_v = '0;
    n_lda = 0; n_add = 0; n_sft = 0; prod = '0;
    start = 1'b1;
    abort = abort_on_start;
    @(posedge clk); #1;
    abort = 1'b0;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      abort     = 1'b0;
      busy_v[c] = busy;
      done_v[c] = done;
      ldm_v[c]  = ldM & clrA & clrff & ~opnd_sel;
      ldq_v[c]  = ldQ & opnd_sel;
      sft_v[c]  = sftA & sftQ;
      if (sftA & sftQ) n_sft++;
      if (ldA) begin
        n_lda++;
        if (addsub) n_add++;
      end
      if (done) prod = {dp_a[15:0], dp_q};
      if (c == abort_at) abort = 1'b1;
      if (hold && c == 37) start = 1'b0;
    end
  endtask

  task automatic run_closed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] exp, input bit with_abort);
    closed = 1'b1; mcand = a; mplier = b;
    run_op(40, 0, 1'b0, with_abort);
    check({tag, "_done"}, done_v, span(35, 35));
    check({tag, "_prod"}, {96'd0, prod}, {96'd0, exp});
    closed = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outs", {ldM, ldQ, ldA, clrA, clrff, sftA, sftQ, addsub, opnd_sel, busy, done}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    fq0 = 1'b1; fqm1 = 1'b0;
    run_op(40, 0, 1'b0, 1'b0);
    check("p10_ldm",  ldm_v, span(1, 1));
    check("p10_ldq",  ldq_v, span(2, 2));
    check("p10_lda",  n_lda, 16);
    check("p10_add",  n_add, 0);
    check("p10_sft",  sft_v, evens(4, 34));
    check("p10_done", done_v, span(35, 35));
    check("p10_busy", busy_v, span(1, 35));

    fq0 = 1'b1; fqm1 = 1'b1;
    run_op(40, 0, 1'b0, 1'b0);
    check("p11_lda",  n_lda, 0);
    check("p11_sft",  n_sft, 16);
    check("p11_done", done_v, span(35, 35));

    fq0 = 1'b0; fqm1 = 1'b1;
    run_op(40, 0, 1'b0, 1'b0);
    check("p01_lda", n_lda, 16);
    check("p01_add", n_add, 16);

    run_closed("m3x5",   16'd3,     16'd5,     32'd15,        1'b0);
    run_closed("mn7x6",  16'hFFF9,  16'd6,     32'hFFFFFFD6,  1'b1);
    run_closed("m8000sq", 16'h8000, 16'h8000,  32'h40000000,  1'b0);

    fq0 = 1'b1; fqm1 = 1'b0;
    run_op(40, 10, 1'b0, 1'b0);
    check("abort_sft10", sft_v[10], 1'b1);
    check("abort_busy",  busy_v, span(1, 10));
    check("abort_done",  done_v, '0);

    run_op(75, 0, 1'b1, 1'b0);
    check("hold_idle", busy_v[36], 1'b0);
    check("hold_ldm",  ldm_v, span(1, 1) | span(37, 37));
    check("hold_done", done_v, span(35, 35) | span(71, 71));

    // asynchronous reset in the middle of an EVAL cycle with a 10 pattern
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_pre_eval", ldA, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {ldM, ldQ, ldA, clrA, clrff, sftA, sftQ, addsub, opnd_sel, busy, done}, '0);
    @(posedge clk); #1;
    check("rst_hold", {ldA, sftA, busy, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(40, 0, 1'b0, 1'b0);
    check("rst_rerun_done", done_v, span(35, 35));

    busy_v = '0; done_v = '0; n_sft = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      busy_v[c] = busy_1;
      done_v[c] = done_1;
      if (sftA_1 & sftQ_1) n_sft++;
      start1 = (c == 2);
    end
    check("n1_done", done_v, span(5, 5));
    check("n1_sft",  n_sft, 1);
    check("n1_busy", busy_v, span(1, 5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
